// File: rtl/pcileech_pcie_tlp_tx_arb_pkg.sv
// Shared types, widths and helpers for the N-source PCIe TLP transmit arbiter.
package pcileech_pcie_tlp_tx_arb_pkg;

   localparam int TLP_DATA_W  = 64;
   localparam int TLP_KEEP_W  = 8;
   localparam int ARB_MAX_SRC = 8;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_GRANT = 2'd1,
      ARB_DROP  = 2'd2
   } arb_state_e;

   function automatic int rr_wrap_inc(input int idx, input int n);
      int nxt;
      nxt = idx + 1;
      if (nxt >= n) begin
         nxt = 0;
      end else begin
         nxt = idx + 1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/pcileech_pcie_tlp_tx_arb_if.sv
// Source-side and core-side AXI-stream bundle of the TLP transmit arbiter.
interface pcileech_pcie_tlp_tx_arb_if #(
   parameter int NUM_SRC = 3
) ();
   import pcileech_pcie_tlp_tx_arb_pkg::*;

   logic [NUM_SRC*TLP_DATA_W-1:0] src_data;
   logic [NUM_SRC*TLP_KEEP_W-1:0] src_keep;
   logic [NUM_SRC-1:0]            src_last;
   logic [NUM_SRC-1:0]            src_valid;
   logic [NUM_SRC-1:0]            src_ready;
   logic [TLP_DATA_W-1:0]         tx_data;
   logic [TLP_KEEP_W-1:0]         tx_keep;
   logic                          tx_last;
   logic                          tx_valid;
   logic                          tx_ready;

   modport master (
      input  src_data, src_keep, src_last, src_valid, tx_ready,
      output src_ready, tx_data, tx_keep, tx_last, tx_valid
   );

   modport slave (
      output src_data, src_keep, src_last, src_valid, tx_ready,
      input  src_ready, tx_data, tx_keep, tx_last, tx_valid
   );

endinterface

// File: rtl/pcileech_rr_pick.sv
// Combinational round-robin picker: first valid source at or after ptr, wrapping.
module pcileech_rr_pick
   import pcileech_pcie_tlp_tx_arb_pkg::*;
#(
   parameter int NUM_SRC = 3,
   localparam int SRC_W = $clog2(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] valid,
   input  logic [SRC_W-1:0]   ptr,
   output logic [SRC_W-1:0]   idx,
   output logic               hit
);

   // scan sources in priority order starting at the pointer
   always_comb begin
      idx = '0;
      hit = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         automatic int cand = (int'(ptr) + i) % NUM_SRC;
         if (!hit && valid[cand]) begin
            idx = SRC_W'(cand);
            hit = 1'b1;
         end else begin
            idx = idx;
         end
      end
   end

endmodule

// File: rtl/pcileech_pcie_tlp_tx_arb.sv
// Round-robin, packet-atomic TLP transmit arbiter in front of the 7-series s_axis_tx port.
// Optional per-source/drop statistics under `PCILEECH_TLP_TX_ARB_STATS_EN.
module pcileech_pcie_tlp_tx_arb
   import pcileech_pcie_tlp_tx_arb_pkg::*;
#(
   parameter int NUM_SRC    = 3,
   parameter int MIN_BUF_AV = 2,
   localparam int SRC_W     = $clog2(NUM_SRC)
) (
   input  logic                       clk_pcie,
   input  logic                       rst,
   input  logic                       user_lnk_up,
   input  logic [5:0]                 tx_buf_av,
   pcileech_pcie_tlp_tx_arb_if.master bus,
   output logic [SRC_W-1:0]           grant_idx,
   output logic                       busy
`ifdef PCILEECH_TLP_TX_ARB_STATS_EN
   ,
   output logic [NUM_SRC*16-1:0]      stat_pkt_cnt,
   output logic [15:0]                stat_drop_cnt
`endif
);

   arb_state_e               state_q, state_d;
   logic [SRC_W-1:0]         grant_idx_q, grant_idx_d;
   logic [SRC_W-1:0]         rr_ptr_q, rr_ptr_d;
   logic [SRC_W-1:0]         pick_idx_s;
   logic                     pick_hit_s;
   logic                     start_ok_s;
   logic                     cur_valid_s;
   logic                     cur_last_s;
   logic                     tx_beat_s;
   logic                     drop_beat_s;
   logic [TLP_DATA_W-1:0]    tx_data_s;
   logic [TLP_KEEP_W-1:0]    tx_keep_s;
   logic                     tx_last_s;
   logic                     tx_valid_s;
   logic [NUM_SRC-1:0]       src_ready_s;

   pcileech_rr_pick #(.NUM_SRC(NUM_SRC)) u_rr_pick (
      .valid (bus.src_valid),
      .ptr   (rr_ptr_q),
      .idx   (pick_idx_s),
      .hit   (pick_hit_s)
   );

   assign cur_valid_s = bus.src_valid[grant_idx_q];
   assign cur_last_s  = bus.src_last[grant_idx_q];
   assign start_ok_s  = user_lnk_up && (int'(tx_buf_av) >= MIN_BUF_AV) && pick_hit_s;
   assign tx_beat_s   = tx_valid_s && bus.tx_ready;
   assign drop_beat_s = (state_q == ARB_DROP) && cur_valid_s;

   // state, grant and round-robin pointer registers
   always_ff @(posedge clk_pcie) begin
      if (rst) begin
         state_q     <= ARB_IDLE;
         grant_idx_q <= '0;
         rr_ptr_q    <= '0;
      end else begin
         state_q     <= state_d;
         grant_idx_q <= grant_idx_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   // next-state: a completed last beat wins over a simultaneous link drop
   always_comb begin
      state_d     = state_q;
      grant_idx_d = grant_idx_q;
      rr_ptr_d    = rr_ptr_q;
      case (state_q)
         ARB_IDLE: begin
            if (start_ok_s) begin
               state_d     = ARB_GRANT;
               grant_idx_d = pick_idx_s;
            end else begin
               state_d     = ARB_IDLE;
            end
         end
         ARB_GRANT: begin
            if (tx_beat_s && tx_last_s) begin
               state_d  = ARB_IDLE;
               rr_ptr_d = SRC_W'(rr_wrap_inc(int'(grant_idx_q), NUM_SRC));
            end else if (!user_lnk_up) begin
               state_d  = ARB_DROP;
            end else begin
               state_d  = ARB_GRANT;
            end
         end
         ARB_DROP: begin
            if (drop_beat_s && cur_last_s) begin
               state_d = ARB_IDLE;
            end else begin
               state_d = ARB_DROP;
            end
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   // outputs: core port follows the granted source; DROP sinks it silently
   always_comb begin
      tx_data_s   = '0;
      tx_keep_s   = '0;
      tx_last_s   = 1'b0;
      tx_valid_s  = 1'b0;
      src_ready_s = '0;
      case (state_q)
         ARB_IDLE: begin
            src_ready_s = '0;
         end
         ARB_GRANT: begin
            tx_data_s                = bus.src_data[TLP_DATA_W*int'(grant_idx_q) +: TLP_DATA_W];
            tx_keep_s                = bus.src_keep[TLP_KEEP_W*int'(grant_idx_q) +: TLP_KEEP_W];
            tx_last_s                = cur_last_s;
            tx_valid_s               = cur_valid_s;
            src_ready_s[grant_idx_q] = bus.tx_ready;
         end
         ARB_DROP: begin
            src_ready_s[grant_idx_q] = 1'b1;
         end
         default: begin
            src_ready_s = '0;
         end
      endcase
   end

   assign bus.tx_data   = tx_data_s;
   assign bus.tx_keep   = tx_keep_s;
   assign bus.tx_last   = tx_last_s;
   assign bus.tx_valid  = tx_valid_s;
   assign bus.src_ready = src_ready_s;
   assign grant_idx     = grant_idx_q;
   assign busy          = (state_q != ARB_IDLE);

`ifdef PCILEECH_TLP_TX_ARB_STATS_EN
   logic [NUM_SRC-1:0][15:0] pkt_cnt_q, pkt_cnt_d;
   logic [15:0]              drop_cnt_q, drop_cnt_d;

   // statistics registers
   always_ff @(posedge clk_pcie) begin
      if (rst) begin
         pkt_cnt_q  <= '0;
         drop_cnt_q <= 16'd0;
      end else begin
         pkt_cnt_q  <= pkt_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // packet counters wrap; the drop counter saturates
   always_comb begin
      pkt_cnt_d  = pkt_cnt_q;
      drop_cnt_d = drop_cnt_q;
      if (tx_beat_s && tx_last_s) begin
         pkt_cnt_d[grant_idx_q] = pkt_cnt_q[grant_idx_q] + 16'd1;
      end else begin
         pkt_cnt_d = pkt_cnt_q;
      end
      if (drop_beat_s && cur_last_s && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end else begin
         drop_cnt_d = drop_cnt_q;
      end
   end

   assign stat_pkt_cnt  = pkt_cnt_q;
   assign stat_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_pcileech_pcie_tlp_tx_arb.sv
// Randomized bench for the TLP transmit arbiter against a cycle-level behavioural model.
module tb_pcileech_pcie_tlp_tx_arb;

   localparam int N      = 3;
   localparam int MIN_AV = 2;
   localparam int NPH    = 5;
   localparam int PH_CYC = 300;

   logic       clk_pcie = 1'b0;
   logic       rst;
   logic       user_lnk_up;
   logic [5:0] tx_buf_av;
   logic [1:0] grant_idx;
   logic       busy;
`ifdef PCILEECH_TLP_TX_ARB_STATS_EN
   logic [N*16-1:0] stat_pkt_cnt;
   logic [15:0]     stat_drop_cnt;
`endif

   pcileech_pcie_tlp_tx_arb_if #(.NUM_SRC(N)) bus ();

   pcileech_pcie_tlp_tx_arb #(.NUM_SRC(N), .MIN_BUF_AV(MIN_AV)) dut (
      .clk_pcie    (clk_pcie),
      .rst         (rst),
      .user_lnk_up (user_lnk_up),
      .tx_buf_av   (tx_buf_av),
      .bus         (bus.master),
      .grant_idx   (grant_idx),
      .busy        (busy)
`ifdef PCILEECH_TLP_TX_ARB_STATS_EN
      ,
      .stat_pkt_cnt  (stat_pkt_cnt),
      .stat_drop_cnt (stat_drop_cnt)
`endif
   );

   always #5 clk_pcie = ~clk_pcie;

   // per-phase stimulus knobs: valid %, ready %, link-up %, credit range, reset %
   int pv    [NPH] = '{100, 70, 100, 85, 75};
   int pr    [NPH] = '{100, 50,  80, 70, 60};
   int pl    [NPH] = '{100, 100, 100, 92, 95};
   int av_lo [NPH] = '{40, 10, 0, 10, 0};
   int av_hi [NPH] = '{63, 63, 3, 63, 63};
   int prst  [NPH] = '{0, 0, 0, 0, 3};

   int n_checks = 0;
   int n_pass   = 0;

   // sources: current packet number, length and beat position
   int pkt [N];
   int len [N];
   int pos [N];
   bit sv  [N];
   bit hs  [N];

   // model: owner=-1 means no grant held
   int m_owner;
   bit m_sink;
   int m_next;
   int m_gidx;
   int m_pkt_cnt [N];
   int m_drop_cnt;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [63:0] beat_word(input int s, input int p, input int b, input int l);
      return {8'(s), 8'hA5, 16'(p), 8'(b), 8'(l), 16'(p * 7 + b)};
   endfunction

   function automatic logic [7:0] beat_keep(input int p, input int b, input int l);
      return (b == l - 1) ? 8'(8'hFF >> (p % 8)) : 8'hFF;
   endfunction

   task automatic drive_inputs(input int ph, input bit force_rst);
      rst          = force_rst || ($urandom_range(99) < prst[ph]);
      user_lnk_up  = ($urandom_range(99) < pl[ph]);
      tx_buf_av    = 6'($urandom_range(av_hi[ph], av_lo[ph]));
      bus.tx_ready = ($urandom_range(99) < pr[ph]);
      for (int i = 0; i < N; i++) begin
         sv[i] = ($urandom_range(99) < pv[ph]);
         bus.src_data[64*i +: 64] = beat_word(i, pkt[i], pos[i], len[i]);
         bus.src_keep[8*i +: 8]   = beat_keep(pkt[i], pos[i], len[i]);
         bus.src_last[i]          = (pos[i] == len[i] - 1);
         bus.src_valid[i]         = sv[i];
      end
   endtask

   task automatic check_outputs();
      logic [63:0]  e_data;
      logic [7:0]   e_keep;
      logic         e_last;
      logic         e_valid;
      logic [N-1:0] e_rdy;
      e_data  = '0;
      e_keep  = '0;
      e_last  = 1'b0;
      e_valid = 1'b0;
      e_rdy   = '0;
      if (m_owner >= 0 && !m_sink) begin
         e_data         = beat_word(m_owner, pkt[m_owner], pos[m_owner], len[m_owner]);
         e_keep         = beat_keep(pkt[m_owner], pos[m_owner], len[m_owner]);
         e_last         = (pos[m_owner] == len[m_owner] - 1);
         e_valid        = sv[m_owner];
         e_rdy[m_owner] = bus.tx_ready;
      end else if (m_owner >= 0) begin
         e_rdy[m_owner] = 1'b1;
      end
      check_eq("tx_valid", 64'(bus.tx_valid), 64'(e_valid));
      check_eq("tx_data", bus.tx_data, e_data);
      check_eq("tx_keep", 64'(bus.tx_keep), 64'(e_keep));
      check_eq("tx_last", 64'(bus.tx_last), 64'(e_last));
      check_eq("src_ready", 64'(bus.src_ready), 64'(e_rdy));
      check_eq("grant_idx", 64'(grant_idx), 64'(m_gidx));
      check_eq("busy", 64'(busy), 64'(m_owner >= 0));
`ifdef PCILEECH_TLP_TX_ARB_STATS_EN
      for (int i = 0; i < N; i++) begin
         check_eq("stat_pkt_cnt", 64'(stat_pkt_cnt[16*i +: 16]), 64'(m_pkt_cnt[i] % 65536));
      end
      check_eq("stat_drop_cnt", 64'(stat_drop_cnt), 64'(m_drop_cnt));
`endif
      for (int i = 0; i < N; i++) begin
         hs[i] = sv[i] && bus.src_ready[i];
      end
   endtask

   task automatic new_packet(input int i);
      pkt[i] = pkt[i] + 1;
      len[i] = $urandom_range(5, 1);
      pos[i] = 0;
   endtask

   // advance model and sources using the values held across the clock edge
   task automatic step_model();
      bit any_v;
      bit o_last;
      if (rst) begin
         m_owner    = -1;
         m_sink     = 1'b0;
         m_next     = 0;
         m_gidx     = 0;
         m_drop_cnt = 0;
         for (int i = 0; i < N; i++) begin
            m_pkt_cnt[i] = 0;
            new_packet(i);
         end
      end else begin
         any_v = 1'b0;
         for (int i = 0; i < N; i++) begin
            any_v = any_v | sv[i];
         end
         if (m_owner < 0) begin
            if (user_lnk_up && (int'(tx_buf_av) >= MIN_AV) && any_v) begin
               for (int k = N - 1; k >= 0; k--) begin
                  if (sv[(m_next + k) % N]) begin
                     m_owner = (m_next + k) % N;
                  end
               end
               m_gidx = m_owner;
            end
         end else begin
            o_last = (pos[m_owner] == len[m_owner] - 1);
            if (!m_sink) begin
               if (sv[m_owner] && bus.tx_ready && o_last) begin
                  m_pkt_cnt[m_owner]++;
                  m_next  = (m_owner + 1) % N;
                  m_owner = -1;
               end else if (!user_lnk_up) begin
                  m_sink = 1'b1;
               end
            end else if (sv[m_owner] && o_last) begin
               if (m_drop_cnt < 65535) begin
                  m_drop_cnt++;
               end
               m_owner = -1;
               m_sink  = 1'b0;
            end
         end
         for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
               if (pos[i] == len[i] - 1) begin
                  new_packet(i);
               end else begin
                  pos[i]++;
               end
            end
         end
      end
   endtask

   initial begin
      int cyc;
      for (int i = 0; i < N; i++) begin
         pkt[i] = 0;
         new_packet(i);
         hs[i] = 1'b0;
      end
      m_owner    = -1;
      m_sink     = 1'b0;
      m_next     = 0;
      m_gidx     = 0;
      m_drop_cnt = 0;
      for (int i = 0; i < N; i++) begin
         m_pkt_cnt[i] = 0;
      end
      drive_inputs(0, 1'b1);
      @(posedge clk_pcie);
      step_model();
      cyc = 0;
      for (int ph = 0; ph < NPH; ph++) begin
         for (int c = 0; c < PH_CYC; c++) begin
            @(negedge clk_pcie);
            drive_inputs(ph, cyc < 2);
            #1;
            check_outputs();
            @(posedge clk_pcie);
            step_model();
            cyc++;
         end
      end
      @(negedge clk_pcie);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
